// File: rtl/eth_pkg.sv
// Shared constants, FSM state type and FCS byte helper for the Ethernet GMII transmit path.
package eth_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
  localparam logic [7:0]  SFD_BYTE        = 8'hD5;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam int unsigned FCS_BYTES       = 4;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    PAYLOAD,
    PAD,
    FCS,
    IFG,
    DROP
  } tx_state_e;

  // Byte idx of the transmitted FCS (complemented CRC register), least significant byte first.
  function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic [1:0] idx);
    logic [31:0] fcs;
    logic [7:0]  b;
    fcs = ~crc;
    case (idx)
      2'd0:    b = fcs[7:0];
      2'd1:    b = fcs[15:8];
      2'd2:    b = fcs[23:16];
      default: b = fcs[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/eth_crc32_byte.sv
// One-byte update of the reflected Ethernet CRC-32; purely combinational so that
// the TX framer and the RX FCS checker can each hold their own CRC register.
module eth_crc32_byte
  import eth_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] c;

  always_comb begin
    c = crc_i;
    // NOTE: blocking assignments here so each loop iteration sees the previous bit's result.
    for (int i = 0; i < 8; i++) begin
      c = (c >> 1) ^ (CRC32_POLY_REFL & {32{c[0] ^ data_i[i]}});
    end
    crc_o = c;
  end

endmodule

// File: rtl/eth_tx_framer.sv
// GMII transmit framer: wraps a valid/ready/last byte stream with preamble, SFD,
// zero padding and FCS, then enforces the inter-frame gap. Underruns abort the frame.
module eth_tx_framer
  import eth_pkg::*;
#(
  parameter int unsigned MIN_FRAME  = 60,
  parameter int unsigned IFG_CYCLES = 12,
  parameter int unsigned PREAMBLE_N = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_tdata,
  input  logic       s_tvalid,
  output logic       s_tready,
  input  logic       s_tlast,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic       busy,
  output logic       underrun
);

  localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_N - 1);
  localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);
  localparam logic [15:0] FCS_LAST = 16'(FCS_BYTES - 1);
  localparam logic [16:0] MIN_LEN  = 17'(MIN_FRAME);

  tx_state_e   state_q;
  logic [15:0] cnt_q;
  logic [15:0] byte_cnt_q;
  logic [15:0] byte_cnt_inc;
  logic [16:0] byte_cnt_nxt;
  logic [31:0] crc_q;
  logic [31:0] crc_d;
  logic [7:0]  crc_data;
  logic [7:0]  txd_q;
  logic        tx_en_q;
  logic        tx_er_q;
  logic        underrun_q;

  // Pad bytes are zeros and still feed the CRC.
  assign crc_data = (state_q == PAD) ? 8'h00 : s_tdata;

  eth_crc32_byte u_crc (
    .crc_i  (crc_q),
    .data_i (crc_data),
    .crc_o  (crc_d)
  );

  // 17-bit view of the count after this byte; bit 16 flags the saturation point.
  assign byte_cnt_nxt = {1'b0, byte_cnt_q} + 17'd1;
  assign byte_cnt_inc = byte_cnt_nxt[16] ? byte_cnt_q : byte_cnt_nxt[15:0];

  assign s_tready   = (state_q == PAYLOAD) || (state_q == DROP);
  assign busy       = (state_q != IDLE);
  assign gmii_txd   = txd_q;
  assign gmii_tx_en = tx_en_q;
  assign gmii_tx_er = tx_er_q;
  assign underrun   = underrun_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      byte_cnt_q <= '0;
      crc_q      <= CRC32_INIT;
      txd_q      <= 8'h00;
      tx_en_q    <= 1'b0;
      tx_er_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      // NOTE: non-blocking for all state; pin outputs default to idle and each state overrides.
      txd_q      <= 8'h00;
      tx_en_q    <= 1'b0;
      tx_er_q    <= 1'b0;
      underrun_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (s_tvalid) begin
            state_q <= PREAMBLE;
            cnt_q   <= '0;
          end
        end

        PREAMBLE: begin
          txd_q   <= PREAMBLE_BYTE;
          tx_en_q <= 1'b1;
          cnt_q   <= cnt_q + 16'd1;
          if (cnt_q == PRE_LAST) begin
            state_q <= SFD;
          end
        end

        SFD: begin
          txd_q      <= SFD_BYTE;
          tx_en_q    <= 1'b1;
          crc_q      <= CRC32_INIT;
          byte_cnt_q <= '0;
          state_q    <= PAYLOAD;
        end

        PAYLOAD: begin
          tx_en_q <= 1'b1;
          if (s_tvalid) begin
            txd_q      <= s_tdata;
            crc_q      <= crc_d;
            byte_cnt_q <= byte_cnt_inc;
            if (s_tlast) begin
              cnt_q   <= '0;
              state_q <= (byte_cnt_nxt < MIN_LEN) ? PAD : FCS;
            end
          end else begin
            // A missing beat mid-frame cannot be recovered: flag it on the wire and abort.
            tx_er_q    <= 1'b1;
            underrun_q <= 1'b1;
            state_q    <= DROP;
          end
        end

        PAD: begin
          tx_en_q    <= 1'b1;
          crc_q      <= crc_d;
          byte_cnt_q <= byte_cnt_inc;
          if (byte_cnt_nxt >= MIN_LEN) begin
            cnt_q   <= '0;
            state_q <= FCS;
          end
        end

        FCS: begin
          txd_q   <= fcs_byte(crc_q, cnt_q[1:0]);
          tx_en_q <= 1'b1;
          cnt_q   <= cnt_q + 16'd1;
          if (cnt_q == FCS_LAST) begin
            cnt_q   <= '0;
            state_q <= IFG;
          end
        end

        IFG: begin
          cnt_q <= cnt_q + 16'd1;
          if (cnt_q == IFG_LAST) begin
            // Launch straight into the next preamble so a waiting frame sees exactly IFG_CYCLES idle edges.
            cnt_q   <= '0;
            state_q <= s_tvalid ? PREAMBLE : IDLE;
          end
        end

        DROP: begin
          if (s_tvalid && s_tlast) begin
            cnt_q   <= '0;
            state_q <= IFG;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
